// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: time-stamps every retired register write for a drain port.
// Optional TRACE_DEDUP_EN suppresses a write identical to the last accepted capture.
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     trace_ready,
    output logic                     trace_valid,
    output logic [ADDR_W-1:0]        trace_addr,
    output logic [DATA_W-1:0]        trace_data,
    output logic [CYC_W-1:0]         trace_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [CYC_W-1:0]  cyc_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CYC_W-1:0] cyc;

    logic dup;
    logic push_req;
    logic full;
    logic pop;
    logic push;
    logic drop;

`ifdef TRACE_DEDUP_EN
    logic              last_valid;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;

    assign dup = last_valid && (last_addr == wb_addr) && (last_data == wb_data);

    // Only accepted pushes define what counts as a repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
            last_data  <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_addr  <= wb_addr;
            last_data  <= wb_data;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign push_req    = wb_valid && (wb_addr != '0) && !dup;
    assign full        = (count == CNT_W'(DEPTH));
    assign trace_valid = (count != '0);
    assign pop         = trace_valid && trace_ready;
    // A pop on a full FIFO frees the slot this same edge.
    assign push        = push_req && (!full || pop);
    assign drop        = push_req && !push;

    assign trace_addr  = addr_mem[rd_ptr];
    assign trace_data  = data_mem[rd_ptr];
    assign trace_cycle = cyc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_mem[wr_ptr] <= wb_addr;
            data_mem[wr_ptr] <= wb_data;
            cyc_mem[wr_ptr]  <= cyc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            cyc        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer; expected values are hand-derived constants.
// Build with +define+TRACE_DEDUP_EN to check the dedup variant.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        trace_ready;
    logic        trace_valid;
    logic [3:0]  trace_addr;
    logic [31:0] trace_data;
    logic [15:0] trace_cycle;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    wb_trace_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .trace_ready (trace_ready),
        .trace_valid (trace_valid),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_cycle (trace_cycle),
        .count       (count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [3:0] a,
                            input logic [31:0] d, input logic [15:0] c);
        chk({tag, "_valid"}, 64'(trace_valid), 64'd1);
        chk({tag, "_addr"},  64'(trace_addr),  64'(a));
        chk({tag, "_data"},  64'(trace_data),  64'(d));
        chk({tag, "_cycle"}, 64'(trace_cycle), 64'(c));
    endtask

    initial begin
        // reset held two cycles with a write pending
        rst = 1'b1; wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'h99;
        trace_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_drop",  64'(drop_count), 64'd0);

        // cycle 0: first post-reset capture
        rst = 1'b0;
        tick();
        wb_valid = 1'b0;
        chk_head("first", 4'd5, 32'h99, 16'd0);
        chk("first_count", 64'(count), 64'd1);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        chk("pop_count", 64'(count), 64'd0);
        chk("pop_valid", 64'(trace_valid), 64'd0);
        tick();
        tick();
        tick();

        // cycle 5: single write, held while not ready
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'hAA;
        chk("nobypass", 64'(trace_valid), 64'd0);
        tick();
        wb_valid = 1'b0;
        chk_head("single", 4'd3, 32'hAA, 16'd5);
        chk("single_count", 64'(count), 64'd1);
        tick();
        tick();
        chk_head("hold", 4'd3, 32'hAA, 16'd5);

        // cycle 8: r0 write ignored
        wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'h1234;
        tick();
        wb_valid = 1'b0;
        chk("r0_count", 64'(count), 64'd1);
        chk("r0_ovf",   64'(overflow), 64'd0);
        chk("r0_drop",  64'(drop_count), 64'd0);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        chk("empty_again", 64'(count), 64'd0);

        // cycles 10..29: 20 writes, last 4 dropped
        for (int i = 0; i < 20; i++) begin
            wb_valid = 1'b1;
            wb_addr  = 4'((i % 15) + 1);
            wb_data  = 32'h100 + 32'(i);
            tick();
        end
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_drop",  64'(drop_count), 64'd4);

        // cycle 30: full with simultaneous pop
        wb_addr = 4'd9; wb_data = 32'hBEEF; trace_ready = 1'b1;
        chk_head("full_head", 4'd1, 32'h100, 16'd10);
        tick();
        wb_valid = 1'b0;
        chk("fullpop_count", 64'(count), 64'd16);
        chk("fullpop_drop",  64'(drop_count), 64'd4);

        for (int j = 1; j < 16; j++) begin
            chk_head("drain", 4'((j % 15) + 1), 32'h100 + 32'(j), 16'(10 + j));
            tick();
        end
        chk_head("drain_last", 4'd9, 32'hBEEF, 16'd30);
        tick();
        trace_ready = 1'b0;
        chk("drained_count", 64'(count), 64'd0);
        chk("drained_valid", 64'(trace_valid), 64'd0);
        chk("ovf_sticky",    64'(overflow), 64'd1);

        // drop counter saturation: 16 kept, 254 more dropped
        for (int k = 0; k < 270; k++) begin
            wb_valid = 1'b1;
            wb_addr  = 4'((k % 15) + 1);
            wb_data  = 32'h2000 + 32'(k);
            tick();
        end
        wb_valid = 1'b0;
        chk("sat_count", 64'(count), 64'd16);
        chk("sat_drop",  64'(drop_count), 64'd255);

        // reset clears everything, then 5 queued entries
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_ovf",   64'(overflow), 64'd0);
        chk("rst2_drop",  64'(drop_count), 64'd0);
        for (int m = 1; m <= 5; m++) begin
            wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 32'h50 + 32'(m);
            tick();
        end
        wb_valid = 1'b0;
        chk("five_count", 64'(count), 64'd5);
        chk_head("five_head", 4'd2, 32'h51, 16'd0);

        // reset mid-operation
        rst = 1'b1; trace_ready = 1'b1;
        tick();
        rst = 1'b0; trace_ready = 1'b0;
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_valid", 64'(trace_valid), 64'd0);

        // repeated (r2, 0x55) after reset
        wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 32'h55;
        tick();
        tick();
        wb_valid = 1'b0;
        chk_head("rep_head", 4'd2, 32'h55, 16'd0);
`ifdef TRACE_DEDUP_EN
        chk("rep_count", 64'(count), 64'd1);
`else
        chk("rep_count", 64'(count), 64'd2);
`endif
        chk("rep_drop", 64'(drop_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
